// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives a 1-cycle synchronous ROM and buffers fetched
// instructions with their addresses in a 2-entry FIFO for the decode stage.
module instr_fetch #(
  parameter int unsigned AWIDTH = 12,
  parameter int unsigned DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_en,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_dout,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_instr,
  output logic [AWIDTH-1:0] out_pc
);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] tag_q, tag_d;
  logic              pending_q, pending_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [DWIDTH-1:0] fifo_instr_q [2];
  logic [DWIDTH-1:0] fifo_instr_d [2];
  logic [AWIDTH-1:0] fifo_pc_q [2];
  logic [AWIDTH-1:0] fifo_pc_d [2];

  logic       pop;
  logic       push;
  logic [2:0] occupancy;

  // Occupancy counts buffered entries plus the read in flight, so a fetch is
  // only issued when its data is guaranteed a free FIFO slot on return.
  always_comb begin
    out_valid = rst_n & (count_q != 2'd0);
    out_instr = fifo_instr_q[rd_ptr_q];
    out_pc    = fifo_pc_q[rd_ptr_q];
    pop       = out_valid & out_ready;
    push      = pending_q & ~redirect;
    occupancy = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
    rom_en    = rst_n & ~redirect & (occupancy <= 3'd1);
    rom_addr  = pc_q;
  end

  always_comb begin
    pc_d         = pc_q;
    tag_d        = tag_q;
    pending_d    = pending_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;

    if (redirect) begin
      // Flush: buffered entries and the returning read are dropped.
      pc_d      = redirect_pc;
      pending_d = 1'b0;
      count_d   = 2'd0;
      rd_ptr_d  = 1'b0;
      wr_ptr_d  = 1'b0;
    end else begin
      pending_d = rom_en;
      if (rom_en) begin
        pc_d  = pc_q + AWIDTH'(1);
        tag_d = pc_q;
      end
      if (push) begin
        fifo_instr_d[wr_ptr_q] = rom_dout;
        fifo_pc_d[wr_ptr_q]    = tag_q;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= '0;
      tag_q     <= '0;
      pending_q <= 1'b0;
      count_q   <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      tag_q        <= tag_d;
      pending_q    <= pending_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected {pc, instr} pairs,
// a negedge monitor compares every accepted instruction against the queue.
module tb_instr_fetch;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout = '0;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  instr_fetch #(
    .AWIDTH (AW),
    .DWIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_dout    (rom_dout),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  // ROM model: mem[i] = 16'h1000 + i, one-cycle synchronous read.
  always @(posedge clk) begin
    if (rom_en) rom_dout <= 16'h1000 + {4'h0, rom_addr};
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [AW+DW-1:0] sb_q[$];
  logic [AW-1:0]    next_pc;
  logic             want_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_n(input int n);
    for (int k = 0; k < n; k++) begin
      sb_q.push_back({next_pc, 16'h1000 + {4'h0, next_pc}});
      next_pc = next_pc + 12'd1;
    end
  endtask

  // Ready is only offered while something is expected, so no item goes unchecked.
  task automatic step();
    @(posedge clk);
    #1;
    out_ready = want_ready && (sb_q.size() > 0);
  endtask

  task automatic drain();
    int n = 0;
    want_ready = 1'b1;
    while (sb_q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_done", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    want_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst_n && out_valid) begin
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          check("mon_unexpected_pop", {20'h0, out_pc}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("mon_pc", {20'h0, out_pc}, {20'h0, e[AW+DW-1:DW]});
          check("mon_instr", {16'h0, out_instr}, {16'h0, e[DW-1:0]});
        end
      end else if (sb_q.size() > 0) begin
        e = sb_q[0];
        check("mon_stall_pc", {20'h0, out_pc}, {20'h0, e[AW+DW-1:DW]});
        check("mon_stall_instr", {16'h0, out_instr}, {16'h0, e[DW-1:0]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    want_ready  = 1'b0;
    next_pc     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_en", {31'h0, rom_en}, 32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_instr", {16'h0, out_instr}, 32'd0);
    check("rst_out_pc", {20'h0, out_pc}, 32'd0);

    // Release with decode always ready: one fetch and one delivery per cycle.
    expect_n(8);
    want_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) rst_n = 1'b1;
      #1;
      check("run_rom_en", {31'h0, rom_en}, 32'd1);
      check("run_rom_addr", {20'h0, rom_addr}, 32'(c));
      check("run_out_valid", {31'h0, out_valid}, (c >= 2) ? 32'd1 : 32'd0);
    end

    // Stall: FIFO fills, fetching stops, head stays put.
    expect_n(6);
    want_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      check("stall_rom_en", {31'h0, rom_en}, 32'd0);
      check("stall_out_valid", {31'h0, out_valid}, 32'd1);
    end
    drain();

    // Redirect with a full FIFO.
    step();
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 12'h080;
    #1;
    check("redir_rom_en", {31'h0, rom_en}, 32'd0);
    check("redir_out_valid", {31'h0, out_valid}, 32'd1);
    step();
    redirect = 1'b0;
    #1;
    check("redir_next_valid", {31'h0, out_valid}, 32'd0);
    check("redir_next_rom_en", {31'h0, rom_en}, 32'd1);
    check("redir_next_addr", {20'h0, rom_addr}, 32'h080);
    next_pc = 12'h080;
    expect_n(4);
    drain();

    // Back-to-back redirects; only the last target (near the wrap) is fetched.
    step();
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 12'h300;
    #1;
    check("b2b_rom_en0", {31'h0, rom_en}, 32'd0);
    step();
    redirect_pc = 12'hFFE;
    #1;
    check("b2b_rom_en1", {31'h0, rom_en}, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check("b2b_addr", {20'h0, rom_addr}, 32'hFFE);
    next_pc = 12'hFFE;
    expect_n(4);
    drain();

    // One-cycle reset with the FIFO full; a concurrent redirect must be ignored.
    step();
    step();
    step();
    rst_n       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 12'h555;
    #1;
    check("mrst_rom_en", {31'h0, rom_en}, 32'd0);
    check("mrst_out_valid", {31'h0, out_valid}, 32'd0);
    step();
    rst_n    = 1'b1;
    redirect = 1'b0;
    #1;
    check("mrst_rel_valid", {31'h0, out_valid}, 32'd0);
    check("mrst_rel_rom_en", {31'h0, rom_en}, 32'd1);
    check("mrst_rel_addr", {20'h0, rom_addr}, 32'd0);
    next_pc = '0;
    expect_n(4);
    want_ready = 1'b1;
    step();
    #1;
    check("mrst_rel1_valid", {31'h0, out_valid}, 32'd0);
    step();
    #1;
    check("mrst_rel2_valid", {31'h0, out_valid}, 32'd1);
    check("mrst_rel2_pc", {20'h0, out_pc}, 32'd0);
    check("mrst_rel2_instr", {16'h0, out_instr}, 32'h1000);
    drain();

    // Random backpressure; the monitor verifies order and data continuously.
    sb_q.delete();
    step();
    redirect    = 1'b1;
    redirect_pc = 12'h7F0;
    step();
    redirect = 1'b0;
    next_pc  = 12'h7F0;
    for (int i = 0; i < 1000; i++) begin
      if (sb_q.size() < 3) expect_n(1);
      want_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
